// File: rtl/if_id_buffer.sv
// if_id_buffer: in-order fetch->decode skid FIFO with redirect flush.
// Define IF_ID_BUFFER_PERF_CNT_EN to add stall/issue/flush performance counters.
module if_id_buffer #(
   parameter int DEPTH = 2,
   parameter int AW    = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] pc_if,
   input  logic        pc_if_valid,
   input  logic [31:0] instruction,
   input  logic        pc_if_err,
   output logic        pc_id_ready,
   input  logic        set_pc_valid,
   output logic        id_valid,
   output logic [31:0] id_pc,
   output logic [31:0] id_instr,
   output logic        id_err,
   output logic        id_compressed,
   input  logic        id_ready
`ifdef IF_ID_BUFFER_PERF_CNT_EN
   ,
   output logic [31:0] perf_stall_cnt,
   output logic [31:0] perf_issue_cnt,
   output logic [31:0] perf_flush_cnt
`endif
);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        err;
   } entry_t;
   entry_t        mem_q [DEPTH];
   entry_t        mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
   logic          push, pop;
   entry_t        head;
   // Outputs are gated by rst_n so nothing stale escapes during a reset cycle.
   assign pc_id_ready   = rst_n && (count_q < AW'(DEPTH));
   assign id_valid      = rst_n && (count_q != '0);
   assign head          = mem_q[rd_ptr_q[IW-1:0]];
   assign id_pc         = id_valid ? head.pc : '0;
   assign id_instr      = id_valid ? head.instr : '0;
   assign id_err        = id_valid && head.err;
   assign id_compressed = id_valid && (head.instr[1:0] != 2'b11);
   assign push          = pc_if_valid && pc_id_ready && !set_pc_valid;
   assign pop           = id_valid && id_ready && !set_pc_valid;
   always_comb begin
      mem_d = mem_q;
      if (push) mem_d[wr_ptr_q[IW-1:0]] = '{pc: pc_if, instr: instruction, err: pc_if_err};
      wr_ptr_d = set_pc_valid ? '0 :
                 !push ? wr_ptr_q :
                 (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
      rd_ptr_d = set_pc_valid ? '0 :
                 !pop ? rd_ptr_q :
                 (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
      count_d  = set_pc_valid ? '0 :
                 (push && !pop) ? count_q + AW'(1) :
                 (pop && !push) ? count_q - AW'(1) : count_q;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end
   // Storage needs no reset: unread slots are never exposed.
   always_ff @(posedge clk) mem_q <= mem_d;
`ifdef IF_ID_BUFFER_PERF_CNT_EN
   logic [31:0] stall_q, stall_d, issue_q, issue_d, flush_q, flush_d;
   always_comb begin
      stall_d = stall_q + 32'(pc_if_valid && !pc_id_ready);
      issue_d = issue_q + 32'(pop);
      flush_d = flush_q + 32'(set_pc_valid && (count_q != '0));
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_q <= '0;
         issue_q <= '0;
         flush_q <= '0;
      end else begin
         stall_q <= stall_d;
         issue_q <= issue_d;
         flush_q <= flush_d;
      end
   end
   assign perf_stall_cnt = stall_q;
   assign perf_issue_cnt = issue_q;
   assign perf_flush_cnt = flush_q;
`endif
endmodule

// File: tb/tb_if_id_buffer.sv
// tb_if_id_buffer: directed self-checking bench for if_id_buffer (DEPTH=2).
// Checks the perf counters too when IF_ID_BUFFER_PERF_CNT_EN is defined.
module tb_if_id_buffer;
   logic        clk, rst_n;
   logic [31:0] pc_if, instruction;
   logic        pc_if_valid, pc_if_err, pc_id_ready, set_pc_valid;
   logic        id_valid, id_err, id_compressed, id_ready;
   logic [31:0] id_pc, id_instr;
   int          errs = 0, checks = 0;
`ifdef IF_ID_BUFFER_PERF_CNT_EN
   logic [31:0] perf_stall_cnt, perf_issue_cnt, perf_flush_cnt;
`endif
   if_id_buffer #(.DEPTH(2), .AW(3)) dut (
      .clk(clk), .rst_n(rst_n), .pc_if(pc_if), .pc_if_valid(pc_if_valid),
      .instruction(instruction), .pc_if_err(pc_if_err), .pc_id_ready(pc_id_ready),
      .set_pc_valid(set_pc_valid), .id_valid(id_valid), .id_pc(id_pc),
      .id_instr(id_instr), .id_err(id_err), .id_compressed(id_compressed),
      .id_ready(id_ready)
`ifdef IF_ID_BUFFER_PERF_CNT_EN
      , .perf_stall_cnt(perf_stall_cnt), .perf_issue_cnt(perf_issue_cnt),
      .perf_flush_cnt(perf_flush_cnt)
`endif
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   // One clock; if the offer was accepted, fetch moves to the next PC.
   task automatic adv();
      logic a;
      a = pc_id_ready && pc_if_valid;
      @(posedge clk);
      #1;
      if (a) pc_if += 32'd4;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end
   initial begin
      int sent, rcv, cyc;
      logic held_v, a;
      logic [31:0] held_pc, held_in, exp_pc;
      rst_n = 1'b0; pc_if = '0; instruction = 32'h13; pc_if_valid = 1'b0;
      pc_if_err = 1'b0; set_pc_valid = 1'b0; id_ready = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      chk("rst_valid", id_valid, 0);
      chk("rst_ready", pc_id_ready, 0);
      chk("rst_pc", id_pc, 0);
      chk("rst_cmp", id_compressed, 0);
`ifdef IF_ID_BUFFER_PERF_CNT_EN
      chk("rst_perf_stall", perf_stall_cnt, 0);
      chk("rst_perf_issue", perf_issue_cnt, 0);
      chk("rst_perf_flush", perf_flush_cnt, 0);
`endif
      rst_n = 1'b1; #1;
      chk("post_rst_ready", pc_id_ready, 1);
      chk("post_rst_valid", id_valid, 0);
      // Streaming at full rate
      pc_if = 32'h8000_0000; pc_if_valid = 1'b1; id_ready = 1'b1; #1;
      for (int k = 0; k < 6; k++) begin
         adv(); #1;
         chk("stream_valid", id_valid, 1);
         chk("stream_pc", id_pc, 32'h8000_0000 + 32'(4 * k));
      end
      pc_if_valid = 1'b0;
      adv(); #1;
      chk("stream_drain", id_valid, 0);
      // Fill to full, third offer held upstream
      pc_if = 32'h8000_0000; pc_if_valid = 1'b1; id_ready = 1'b0; #1;
      adv(); #1;
      chk("fill_head0", id_pc, 32'h8000_0000);
      chk("fill_ready1", pc_id_ready, 1);
      adv(); #1;
      chk("fill_full", pc_id_ready, 0);
      adv(); adv(); #1;
      chk("fill_hold_pc", id_pc, 32'h8000_0000);
      chk("fill_hold_ready", pc_id_ready, 0);
      id_ready = 1'b1;
      adv(); #1;
      chk("fill_out1", id_pc, 32'h8000_0004);
      adv(); #1;
      chk("fill_out2", id_pc, 32'h8000_0008);
      pc_if_valid = 1'b0;
      adv(); #1;
      chk("fill_empty", id_valid, 0);
      // Flush while full with a simultaneous offer
      pc_if = 32'h8000_0008; pc_if_valid = 1'b1; id_ready = 1'b0; #1;
      adv(); adv(); #1;
      chk("flush_full", pc_id_ready, 0);
      chk("flush_offer", pc_if, 32'h8000_0010);
      set_pc_valid = 1'b1;
      adv();
      set_pc_valid = 1'b0; pc_if = 32'h8000_0020; #1;
      chk("flush_valid", id_valid, 0);
      chk("flush_pc", id_pc, 0);
      chk("flush_ready", pc_id_ready, 1);
      id_ready = 1'b1;
      adv(); #1;
      chk("flush_newhead", id_pc, 32'h8000_0020);
      pc_if_valid = 1'b0;
      adv(); #1;
      // Back-to-back flushes keep the buffer empty
      set_pc_valid = 1'b1; pc_if_valid = 1'b1; pc_if = 32'h8000_0030; #1;
      chk("bb_ready0", pc_id_ready, 1);
      adv(); #1;
      chk("bb_valid1", id_valid, 0);
      chk("bb_ready1", pc_id_ready, 1);
      adv(); #1;
      chk("bb_valid2", id_valid, 0);
      set_pc_valid = 1'b0; pc_if_valid = 1'b0; #1;
`ifdef IF_ID_BUFFER_PERF_CNT_EN
      chk("perf_flush", perf_flush_cnt, 1);
`endif
      // Entry attributes
      pc_if = 32'h8000_0100; instruction = 32'h0000_4501; pc_if_err = 1'b1;
      pc_if_valid = 1'b1; id_ready = 1'b0; #1;
      adv();
      pc_if_valid = 1'b0; #1;
      chk("attr_cmp1", id_compressed, 1);
      chk("attr_err1", id_err, 1);
      chk("attr_instr1", id_instr, 32'h0000_4501);
      instruction = 32'h0000_0013; pc_if_err = 1'b0; pc_if_valid = 1'b1; id_ready = 1'b1; #1;
      adv();
      pc_if_valid = 1'b0; #1;
      chk("attr_cmp0", id_compressed, 0);
      chk("attr_err0", id_err, 0);
      chk("attr_instr0", id_instr, 32'h0000_0013);
      adv(); #1;
      // Stall/resume over 100 entries
      sent = 0; rcv = 0; held_v = 1'b0; held_pc = '0; held_in = '0;
      for (cyc = 0; cyc < 1000 && rcv < 100; cyc++) begin
         id_ready = ((cyc / 10) % 2) == 1;
         pc_if_valid = sent < 100;
         pc_if = 32'h9000_0000 + 32'(4 * sent);
         instruction = ~pc_if;
         #1;
         if (held_v) begin
            chk("stall_pc_stable", id_pc, held_pc);
            chk("stall_in_stable", id_instr, held_in);
         end
         if (id_valid && id_ready) begin
            exp_pc = 32'h9000_0000 + 32'(4 * rcv);
            chk("sr_pc", id_pc, exp_pc);
            chk("sr_instr", id_instr, ~exp_pc);
            rcv++;
         end
         held_v = id_valid && !id_ready;
         held_pc = id_pc;
         held_in = id_instr;
         a = pc_id_ready && pc_if_valid;
         @(posedge clk); #1;
         if (a) sent++;
      end
      chk("sr_count", 32'(rcv), 100);
      pc_if_valid = 1'b0; id_ready = 1'b1;
      adv(); adv(); #1;
      chk("sr_empty", id_valid, 0);
      // Reset mid-stream with two buffered entries
      pc_if = 32'h8000_0200; instruction = 32'h13; pc_if_valid = 1'b1; id_ready = 1'b0; #1;
      adv(); adv(); #1;
      chk("mr_full", pc_id_ready, 0);
      rst_n = 1'b0; pc_if_valid = 1'b0; #1;
      chk("mr_valid", id_valid, 0);
      chk("mr_ready", pc_id_ready, 0);
      chk("mr_pc", id_pc, 0);
      adv();
      rst_n = 1'b1; #1;
      chk("mr_ready_after", pc_id_ready, 1);
      chk("mr_valid_after", id_valid, 0);
`ifdef IF_ID_BUFFER_PERF_CNT_EN
      chk("mr_perf_stall", perf_stall_cnt, 0);
      chk("mr_perf_issue", perf_issue_cnt, 0);
      chk("mr_perf_flush", perf_flush_cnt, 0);
`endif
      pc_if = 32'h8000_0300; pc_if_valid = 1'b1; #1;
      adv();
      pc_if_valid = 1'b0; #1;
      chk("mr_new_head", id_pc, 32'h8000_0300);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/if_id_buffer.md
Name: if_id_buffer

Overview:
- Decoupling buffer between the fetch stage and the decode stage, directly downstream of the fetch stage.
- Accepts {pc, instruction, fetch error} from fetch under a valid/ready handshake. Holds up to DEPTH entries in order and presents them to decode under a second valid/ready handshake.
- Drives the fetch stage's pc_id_ready. Discards all buffered entries on a redirect (set_pc_valid) so that no wrong-path instruction reaches decode.

Parameters:
- DEPTH, 2, number of buffered entries; legal range 2..8, not restricted to powers of two.
- AW, 3, pointer/count width; must satisfy 2^AW > DEPTH.

Ports:
- clk  input  1  core clock, all state on rising edge
- rst_n  input  1  reset, synchronous, active-low
- pc_if  input  32  PC of the fetched instruction
- pc_if_valid  input  1  fetch offers an entry this cycle
- instruction  input  32  fetched instruction word
- pc_if_err  input  1  bus error on this fetch
- pc_id_ready  output  1  buffer can accept an entry this cycle
- set_pc_valid  input  1  redirect/flush request
- id_valid  output  1  head entry valid for decode
- id_pc  output  32  head entry PC
- id_instr  output  32  head entry instruction
- id_err  output  1  head entry fetch error
- id_compressed  output  1  head entry is a 16-bit encoding, i.e. id_instr[1:0] != 2'b11
- id_ready  input  1  decode consumes the head entry this cycle

Behaviour:
- Reset: rst_n sampled low at a clk edge clears count, rd_ptr and wr_ptr to 0. During reset: id_valid=0; id_pc, id_instr, id_err, id_compressed=0; pc_id_ready=0. pc_id_ready=1 on the first cycle after rst_n is sampled high. Reset asserted mid-operation discards all entries identically.
- Storage: DEPTH-entry circular array of {pc[31:0], instr[31:0], err}. wr_ptr and rd_ptr wrap from DEPTH-1 to 0 by explicit compare. count ranges 0..DEPTH.
- pc_id_ready = (count < DEPTH) && !reset-cycle. It is a function of registered count only, with no combinational path from id_ready.
- Push occurs when pc_if_valid && pc_id_ready && !set_pc_valid. The entry is written at wr_ptr and wr_ptr advances.
- Pop occurs when id_valid && id_ready && !set_pc_valid. rd_ptr advances.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- id_valid = (count != 0). Outputs read the entry at rd_ptr. When count==0, id_pc/id_instr/id_err/id_compressed are forced to 0.
- Latency: an entry pushed at edge N is visible on id_* from edge N onward (1 cycle). There is no same-cycle bypass.
- Throughput: 1 entry/cycle sustained when id_ready=1.
- Full: count==DEPTH gives pc_id_ready=0. The upstream entry is held by the fetch stage and never dropped or overwritten.
- Empty: id_ready is ignored and the pointers do not move.
- Flush: set_pc_valid=1 at an edge sets count=0 and rd_ptr=wr_ptr=0. That cycle's push and pop are both suppressed, so the offered input is dropped. id_valid=0 in the next cycle. Flush has priority over push and pop.
- Back-to-back flushes hold the buffer empty. pc_id_ready stays 1 throughout a flush.
- id_* outputs are held stable while id_valid=1 and id_ready=0.

Optional Feature:
- Macro: IF_ID_BUFFER_PERF_CNT_EN.
- When defined, the block adds three 32-bit output ports, all reset to 0, all incrementing on rising edges and wrapping 0xFFFF_FFFF -> 0:
  - perf_stall_cnt: increments on each cycle with pc_if_valid && !pc_id_ready.
  - perf_issue_cnt: increments on each pop.
  - perf_flush_cnt: increments on each cycle with set_pc_valid=1 and count!=0.
- When undefined, these ports and their logic are absent, and behaviour is otherwise identical.

Test Plan:
- Reset then stream: hold pc_if_valid=1 with pc_if=0x8000_0000, +4 per accept, and id_ready=1 -> id_valid rises 1 cycle after the first accept. id_pc sequence is 0x8000_0000, 0x8000_0004, ... with no gaps and no duplicates.
- Fill with DEPTH=2, id_ready=0, 3 offers (0x8000_0000/04/08) -> pc_id_ready=0 after 2 accepts; 0x8000_0008 is held upstream. Then id_ready=1 -> all three are delivered in order.
- Flush while full: 2 entries buffered, set_pc_valid=1 for one cycle with a simultaneous offer of 0x8000_0010 -> next cycle id_valid=0 and count=0. 0x8000_0010 is never delivered. The next accepted entry appears at the head.
- Stall/resume (id_ready 0 for 10 cycles, then 1 for 10 cycles, repeated) -> id_* stable while stalled; no loss or reorder across 100 entries; pointer wrap exercised.
- Entry attributes: instruction=0x0000_4501 with pc_if_err=1 -> id_compressed=1, id_err=1. instruction=0x0000_0013 -> id_compressed=0, id_err=0.
- Reset mid-stream (rst_n=0 for 1 cycle with 2 entries buffered) -> id_valid=0, pc_id_ready=0 during reset, pc_id_ready=1 the next cycle. With IF_ID_BUFFER_PERF_CNT_EN defined, the counters read 0 after reset, and perf_flush_cnt=1 after the flush scenario.
